gray_wptr_full: RTL and testbench

GRAY_WPTR_FULL -- requirements
Module: gray_wptr_full

---
 rtl/gray_wptr_full_pkg.sv | 33 +++
 rtl/gray_wptr_full_b2gconverter.sv | 17 +
 rtl/gray_wptr_full.sv | 109 ++++++++++
 tb/tb_gray_wptr_full.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/gray_wptr_full_pkg.sv
// ----------------------------------------------------------------------------
// gray_wptr_full_pkg
// Shared FIFO helpers for the Gray-coded pointer logic.
//   ptr_w_of(width)  : pointer width (one wrap bit above the address bits)
//   depth_of(width)  : number of FIFO entries
//   g2b(gray)        : Gray-to-binary converter; any pointer up to 32 bits,
//                      with the unused upper bits driven to zero.
// ----------------------------------------------------------------------------
package gray_wptr_full_pkg;

   localparam int DEFAULT_WIDTH = 4;

   // Pointer width: address bits plus the wrap bit that separates full from empty.
   function automatic int ptr_w_of(input int width);
      return width + 1;
   endfunction

   // FIFO depth in entries.
   function automatic int depth_of(input int width);
      return 32'sd1 << width;
   endfunction

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [31:0] g2b(input logic [31:0] gray);
      logic [31:0] bin;
      bin = gray;
      for (int i = 30; i >= 0; i--) begin
         bin[i] = bin[i + 1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray_wptr_full_b2gconverter.sv
// ----------------------------------------------------------------------------
// b2gconverter
// Combinational binary-to-Gray converter.
//   n        : vector width
//   data_in  : binary value
//   data_out : Gray-coded value (data_in ^ (data_in >> 1))
// ----------------------------------------------------------------------------
module b2gconverter #(
   parameter int n = 5
) (
   input  logic [n-1:0] data_in,
   output logic [n-1:0] data_out
);

   assign data_out = data_in ^ {1'b0, data_in[n-1:1]};

endmodule

// File: rtl/gray_wptr_full.sv
// ----------------------------------------------------------------------------
// gray_wptr_full
// Write-side pointer and full-flag logic of an asynchronous FIFO.
// Optional feature: define GRAY_WPTR_ALMOST_FULL_EN to add the almost_full
// output (threshold af_margin free entries).
//   clk         : write-domain clock
//   rst         : synchronous active-high reset
//   winc        : write request
//   rptr_gray   : read pointer, Gray code, from the read domain (asynchronous)
//   wen         : write accepted this cycle (memory write enable)
//   waddr       : memory write address
//   wptr_gray   : registered Gray write pointer for the read domain
//   full        : registered FIFO-full flag
//   almost_full : registered almost-full flag (only with the macro)
// ----------------------------------------------------------------------------
module gray_wptr_full
   import gray_wptr_full_pkg::*;
#(
   parameter int width     = 4,
   parameter int af_margin = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             winc,
   input  logic [width:0]   rptr_gray,
   output logic             wen,
   output logic [width-1:0] waddr,
   output logic [width:0]   wptr_gray,
   output logic             full
`ifdef GRAY_WPTR_ALMOST_FULL_EN
   ,
   output logic             almost_full
`endif
);

   localparam int PTR_W = ptr_w_of(width);

   // The full comparison needs at least two pointer MSBs plus one lower bit.
   if (width < 2 || af_margin < 0 || af_margin > depth_of(width)) begin : g_param_check
      $error("gray_wptr_full: unsupported width or af_margin");
   end

   logic [PTR_W-1:0] wbin_r;
   logic [PTR_W-1:0] rq1_r;
   logic [PTR_W-1:0] rq2_r;
   logic [PTR_W-1:0] wbin_next_s;
   logic [PTR_W-1:0] wgray_next_s;
   logic             full_next_s;

   assign wen         = winc & ~full;
   assign waddr       = wbin_r[width-1:0];
   assign wbin_next_s = wbin_r + {{width{1'b0}}, wen};

   b2gconverter #(
      .n (PTR_W)
   ) u_b2g (
      .data_in  (wbin_next_s),
      .data_out (wgray_next_s)
   );

   // Full when the next write pointer equals the read pointer with the two
   // Gray MSBs inverted, i.e. exactly one lap ahead.
   assign full_next_s = (wgray_next_s == {~rq2_r[width:width-1], rq2_r[width-2:0]});

   // Two-flop synchronizer for the read pointer coming from the read domain.
   always_ff @(posedge clk) begin
      if (rst) begin
         rq1_r <= {PTR_W{1'b0}};
         rq2_r <= {PTR_W{1'b0}};
      end else begin
         rq1_r <= rptr_gray;
         rq2_r <= rq1_r;
      end
   end

   // Binary/Gray write pointer registers and the full flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wbin_r    <= {PTR_W{1'b0}};
         wptr_gray <= {PTR_W{1'b0}};
         full      <= 1'b0;
      end else begin
         wbin_r    <= wbin_next_s;
         wptr_gray <= wgray_next_s;
         full      <= full_next_s;
      end
   end

`ifdef GRAY_WPTR_ALMOST_FULL_EN
   localparam int DEPTH = depth_of(width);

   logic [PTR_W-1:0] rbin_sync_s;
   logic [PTR_W-1:0] fill_s;

   // Occupancy as seen by the writer; modulo arithmetic handles the wrap bit.
   assign rbin_sync_s = PTR_W'(g2b({{(32-PTR_W){1'b0}}, rq2_r}));
   assign fill_s      = wbin_next_s - rbin_sync_s;

   // Almost-full register; the threshold never exceeds DEPTH so it also covers full.
   always_ff @(posedge clk) begin
      if (rst) begin
         almost_full <= 1'b0;
      end else begin
         almost_full <= (fill_s >= PTR_W'(DEPTH - af_margin));
      end
   end
`endif

endmodule

// File: tb/tb_gray_wptr_full.sv
// ----------------------------------------------------------------------------
// tb_gray_wptr_full
// Self-checking bench for gray_wptr_full with width=2 (depth 4), af_margin=1.
// Directed vector table, a wrap-around sequence, then randomized traffic
// against a count-based reference model.
// ----------------------------------------------------------------------------
module tb_gray_wptr_full;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       winc = 1'b0;
   logic [2:0] rptr_gray = 3'b000;
   logic       wen;
   logic [1:0] waddr;
   logic [2:0] wptr_gray;
   logic       full;
`ifdef GRAY_WPTR_ALMOST_FULL_EN
   logic       almost_full;
`endif

   int checks = 0;
   int errors = 0;

   gray_wptr_full #(
      .width     (2),
      .af_margin (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .winc        (winc),
      .rptr_gray   (rptr_gray),
      .wen         (wen),
      .waddr       (waddr),
      .wptr_gray   (wptr_gray),
      .full        (full)
`ifdef GRAY_WPTR_ALMOST_FULL_EN
      ,
      .almost_full (almost_full)
`endif
   );

   always #5 clk = ~clk;

   // Gray sequence of a 3-bit pointer, listed explicitly.
   logic [2:0] gseq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

   // Reference model: write count mod 8, read pointer history as seen by the writer.
   int         m_w = 0;
   int         m_wtot = 0;
   bit         m_full = 1'b0;
   bit         m_af = 1'b0;
   logic [2:0] hist[$] = '{3'b000, 3'b000};

   function automatic int gray_to_count(input logic [2:0] g);
      for (int i = 0; i < 8; i++) begin
         if (gseq[i] == g) return i;
      end
      return 0;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   // Advance the model by one edge using the inputs applied for that edge.
   task automatic model_edge();
      int used;
      if (rst) begin
         m_w    = 0;
         m_wtot = 0;
         m_full = 1'b0;
         m_af   = 1'b0;
         hist   = '{3'b000, 3'b000};
      end else begin
         if (winc && !m_full) begin
            m_w = (m_w + 1) % 8;
            m_wtot++;
         end
         // The writer sees the read pointer sampled two edges earlier.
         used   = (m_w - gray_to_count(hist[0]) + 8) % 8;
         m_full = (used == 4);
         m_af   = (used >= 3);
         hist.push_back(rptr_gray);
         void'(hist.pop_front());
      end
   endtask

   // One clock: drive inputs at negedge, sample wen before the edge,
   // update the model at the edge, optionally compare registered outputs.
   task automatic cycle(input logic r, input logic w, input logic [2:0] rp,
                        input bit chk_model, output logic pre_wen);
      bit exp_wen;
      @(negedge clk);
      rst = r;
      winc = w;
      rptr_gray = rp;
      #1;
      pre_wen = wen;
      exp_wen = w && !m_full && !r;
      if (chk_model && !r) chk("rnd_wen", {7'b0, wen}, {7'b0, exp_wen});
      @(posedge clk);
      model_edge();
      #1;
      if (chk_model) begin
         chk("rnd_wptr_gray", {5'b0, wptr_gray}, {5'b0, gseq[m_w]});
         chk("rnd_waddr", {6'b0, waddr}, 8'(m_w % 4));
         chk("rnd_full", {7'b0, full}, {7'b0, m_full});
`ifdef GRAY_WPTR_ALMOST_FULL_EN
         chk("rnd_almost_full", {7'b0, almost_full}, {7'b0, m_af});
`endif
      end
   endtask

   typedef struct {
      logic       rst;
      logic       winc;
      logic [2:0] rptr;
      logic       chk_wen;
      logic       wen;
      logic [1:0] waddr;
      logic [2:0] gray;
      logic       full;
      logic       af;
   } vec_t;

   vec_t vecs[11];

   initial begin
      logic pw;
      int   rcnt;
      logic r, w;

      // rst, winc, rptr, chk_wen, wen(pre-edge), waddr, wptr_gray, full, almost_full (post-edge)
      vecs[0]  = '{1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 2'b01, 3'b001, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 2'b10, 3'b011, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 2'b11, 3'b010, 1'b0, 1'b1};
      vecs[5]  = '{1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 2'b00, 3'b110, 1'b1, 1'b1};
      vecs[6]  = '{1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 2'b00, 3'b110, 1'b1, 1'b1};
      vecs[7]  = '{1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 2'b00, 3'b110, 1'b1, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 2'b00, 3'b110, 1'b1, 1'b1};
      vecs[9]  = '{1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 2'b00, 3'b110, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 1'b1, 3'b001, 1'b1, 1'b1, 2'b01, 3'b111, 1'b1, 1'b1};

      // Reset, Gray stepping, full blocking and delayed release.
      for (int i = 0; i < 11; i++) begin
         cycle(vecs[i].rst, vecs[i].winc, vecs[i].rptr, 1'b0, pw);
         if (vecs[i].chk_wen) chk($sformatf("tbl%0d_wen", i), {7'b0, pw}, {7'b0, vecs[i].wen});
         chk($sformatf("tbl%0d_waddr", i), {6'b0, waddr}, {6'b0, vecs[i].waddr});
         chk($sformatf("tbl%0d_wptr_gray", i), {5'b0, wptr_gray}, {5'b0, vecs[i].gray});
         chk($sformatf("tbl%0d_full", i), {7'b0, full}, {7'b0, vecs[i].full});
`ifdef GRAY_WPTR_ALMOST_FULL_EN
         chk($sformatf("tbl%0d_almost_full", i), {7'b0, almost_full}, {7'b0, vecs[i].af});
`endif
      end

      // Wrap-around: reset, then 8 writes with the read pointer trailing.
      cycle(1'b1, 1'b0, 3'b000, 1'b0, pw);
      cycle(1'b1, 1'b0, 3'b000, 1'b0, pw);
      rcnt = 0;
      for (int i = 0; i < 8; i++) begin
         rcnt = i;
         cycle(1'b0, 1'b1, gseq[i], 1'b1, pw);
         if (i == 6) begin
            chk("wrap_gray_100", {5'b0, wptr_gray}, 8'b0000_0100);
            chk("wrap_waddr_11", {6'b0, waddr}, 8'b0000_0011);
         end
      end
      chk("wrap_gray_000", {5'b0, wptr_gray}, 8'b0000_0000);
      chk("wrap_waddr_00", {6'b0, waddr}, 8'b0000_0000);
      chk("wrap_no_full", {7'b0, full}, 8'b0000_0000);

      // Randomized traffic: reads consume only committed writes; rare resets.
      for (int n = 0; n < 600; n++) begin
         r = ($urandom_range(0, 99) == 0);
         w = ($urandom_range(0, 3) != 0);
         if (r) begin
            rcnt = 0;
         end else if (rcnt < m_wtot && $urandom_range(0, 1) == 1) begin
            rcnt++;
         end
         cycle(r, w, gseq[rcnt % 8], 1'b1, pw);
         if (r) rcnt = 0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
